// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
// Owner encoding records which requester holds the response slot next cycle.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_STARVE_MAX = 4;
   localparam int STARVE_CTR_W   = 4;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      D_RD = 2'd2,
      D_WR = 2'd3
   } owner_e;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Fetch starvation counter: counts consecutive cycles in which fetch is
// waiting but loses, and raises o_force once the limit is reached.
// Only built and used when MEM_ARBITER_FAIR_EN is defined.
`ifdef MEM_ARBITER_FAIR_EN
module arb_starve_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_if_valid,
   input  logic i_if_grant,
   output logic o_force
);

   localparam logic [STARVE_CTR_W-1:0] LP_MAX = STARVE_CTR_W'(STARVE_MAX);

   logic [STARVE_CTR_W-1:0] r_cnt;

   // Count fetch denials; clear when fetch wins or stops asking, saturate at all-ones.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_if_valid || i_if_grant) begin
         r_cnt <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_force = (r_cnt == LP_MAX);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction
// fetch and the data (load/store) port. Data has priority; the grant is
// same-cycle and the read data is routed back one cycle later via an owner
// register. Optional fetch anti-starvation is enabled by MEM_ARBITER_FAIR_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                i_clk,
   input  logic                i_rst,
   // fetch port
   input  logic                i_if_req_valid,
   output logic                o_if_req_ready,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_rsp_valid,
   output logic [DATA_W-1:0]   o_if_rsp_data,
   // data port
   input  logic                i_d_req_valid,
   output logic                o_d_req_ready,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic                i_d_we,
   input  logic [DATA_W-1:0]   i_d_wdata,
   input  logic [DATA_W/8-1:0] i_d_wstrb,
   output logic                o_d_rsp_valid,
   output logic [DATA_W-1:0]   o_d_rsp_data,
   // memory port
   output logic                o_mem_en,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic                o_mem_we,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_wstrb,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   // Reject configurations the byte strobes and 4-bit counter cannot represent.
   if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("mem_arbiter: DATA_W must be a multiple of 8");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be in 1..15");
   end

   owner_e r_owner;
   owner_e w_owner_nxt;
   logic   w_if_gnt;
   logic   w_d_gnt;
   logic   w_force_if;

`ifdef MEM_ARBITER_FAIR_EN
   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_if_valid (i_if_req_valid),
      .i_if_grant (w_if_gnt),
      .o_force    (w_force_if)
   );
`else
   assign w_force_if = 1'b0;
`endif

   // Grant: data wins unless fetch is being forced; nothing is granted in reset.
   always_comb begin
      w_if_gnt = !i_rst && i_if_req_valid && (!i_d_req_valid || w_force_if);
      w_d_gnt  = !i_rst && i_d_req_valid && !w_if_gnt;
   end

   assign o_if_req_ready = w_if_gnt;
   assign o_d_req_ready  = w_d_gnt;

   // Memory drive and next owner follow the winner; idle drives all zeros.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_addr  = '0;
      o_mem_we    = 1'b0;
      o_mem_wdata = '0;
      o_mem_wstrb = '0;
      w_owner_nxt = NONE;
      if (w_if_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_addr  = i_if_addr;
         w_owner_nxt = IF;
      end else if (w_d_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_addr  = i_d_addr;
         o_mem_we    = i_d_we;
         o_mem_wdata = i_d_wdata;
         o_mem_wstrb = i_d_wstrb;
         w_owner_nxt = i_d_we ? D_WR : D_RD;
      end
   end

   // Owner register: updated every cycle so back-to-back grants pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_owner <= NONE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Response routing one cycle after the grant; write acks carry zero data.
   always_comb begin
      o_if_rsp_valid = 1'b0;
      o_if_rsp_data  = '0;
      o_d_rsp_valid  = 1'b0;
      o_d_rsp_data   = '0;
      unique case (r_owner)
         IF: begin
            o_if_rsp_valid = 1'b1;
            o_if_rsp_data  = i_mem_rdata;
         end
         D_RD: begin
            o_d_rsp_valid = 1'b1;
            o_d_rsp_data  = i_mem_rdata;
         end
         D_WR: begin
            o_d_rsp_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors drive both ports, grant-side
// outputs are compared directly, and expected responses go into per-port
// queues that a monitor pops whenever the DUT raises a response valid.
// Run with or without MEM_ARBITER_FAIR_EN (STARVE_MAX left at 4).
module tb_mem_arbiter;

   logic        i_clk;
   logic        i_rst;
   logic        i_if_req_valid;
   logic        o_if_req_ready;
   logic [31:0] i_if_addr;
   logic        o_if_rsp_valid;
   logic [31:0] o_if_rsp_data;
   logic        i_d_req_valid;
   logic        o_d_req_ready;
   logic [31:0] i_d_addr;
   logic        i_d_we;
   logic [31:0] i_d_wdata;
   logic [3:0]  i_d_wstrb;
   logic        o_d_rsp_valid;
   logic [31:0] o_d_rsp_data;
   logic        o_mem_en;
   logic [31:0] o_mem_addr;
   logic        o_mem_we;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic [31:0] i_mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   logic [31:0] mem [256];

   mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_if_req_valid (i_if_req_valid),
      .o_if_req_ready (o_if_req_ready),
      .i_if_addr      (i_if_addr),
      .o_if_rsp_valid (o_if_rsp_valid),
      .o_if_rsp_data  (o_if_rsp_data),
      .i_d_req_valid  (i_d_req_valid),
      .o_d_req_ready  (o_d_req_ready),
      .i_d_addr       (i_d_addr),
      .i_d_we         (i_d_we),
      .i_d_wdata      (i_d_wdata),
      .i_d_wstrb      (i_d_wstrb),
      .o_d_rsp_valid  (o_d_rsp_valid),
      .o_d_rsp_data   (o_d_rsp_data),
      .o_mem_en       (o_mem_en),
      .o_mem_addr     (o_mem_addr),
      .o_mem_we       (o_mem_we),
      .o_mem_wdata    (o_mem_wdata),
      .o_mem_wstrb    (o_mem_wstrb),
      .i_mem_rdata    (i_mem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Synchronous single-port memory model (word index = addr[9:2]).
   always @(posedge i_clk) begin
      if (o_mem_en) begin
         if (o_mem_we) mem[o_mem_addr[9:2]] <= merge(mem[o_mem_addr[9:2]], o_mem_wdata, o_mem_wstrb);
         else          i_mem_rdata <= mem[o_mem_addr[9:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop the expected response whenever a response valid is seen.
   always @(negedge i_clk) begin : monitor
      logic [31:0] e;
      if (o_if_rsp_valid) begin
         if (if_q.size() == 0) check("if_rsp_unexpected", 32'd1, 32'd0);
         else begin
            e = if_q.pop_front();
            check("if_rsp_data", o_if_rsp_data, e);
         end
      end
      if (o_d_rsp_valid) begin
         if (d_q.size() == 0) check("d_rsp_unexpected", 32'd1, 32'd0);
         else begin
            e = d_q.pop_front();
            check("d_rsp_data", o_d_rsp_data, e);
         end
      end
   end

   // One arbitration cycle: drive at negedge, check grant-side outputs,
   // and queue the response the winner must see next cycle.
   task automatic cycle(input logic if_v, input logic [31:0] if_a,
                        input logic d_v, input logic d_we, input logic [31:0] d_a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic exp_if, input logic exp_d, input logic [31:0] exp_rsp);
      logic [31:0] exp_addr;
      @(negedge i_clk);
      i_if_req_valid = if_v;
      i_if_addr      = if_a;
      i_d_req_valid  = d_v;
      i_d_we         = d_we;
      i_d_addr       = d_a;
      i_d_wdata      = wd;
      i_d_wstrb      = ws;
      #1;
      exp_addr = exp_if ? if_a : (exp_d ? d_a : 32'd0);
      check("if_req_ready", {31'd0, o_if_req_ready}, {31'd0, exp_if});
      check("d_req_ready",  {31'd0, o_d_req_ready},  {31'd0, exp_d});
      check("mem_en",       {31'd0, o_mem_en},       {31'd0, exp_if | exp_d});
      check("mem_addr",     o_mem_addr, exp_addr);
      check("mem_we",       {31'd0, o_mem_we},       {31'd0, exp_d & d_we});
      check("mem_wstrb",    {28'd0, o_mem_wstrb},    {28'd0, (exp_d & d_we) ? ws : 4'd0});
      if (exp_d && d_we) check("mem_wdata", o_mem_wdata, wd);
      if (exp_if) if_q.push_back(exp_rsp);
      if (exp_d)  d_q.push_back(d_we ? 32'd0 : exp_rsp);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic exp_if;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0]  = 32'h0000_0011;
      mem[1]  = 32'h0000_0022;
      mem[2]  = 32'h0000_0033;
      mem[16] = 32'h1234_5678;   // 0x40
      mem[64] = 32'hCAFE_F00D;   // 0x100
      i_mem_rdata    = 32'd0;
      i_rst          = 1'b1;
      i_if_req_valid = 1'b0;
      i_if_addr      = 32'd0;
      i_d_req_valid  = 1'b0;
      i_d_addr       = 32'd0;
      i_d_we         = 1'b0;
      i_d_wdata      = 32'd0;
      i_d_wstrb      = 4'd0;

      // Reset state: no responses, grants forced low even with requests up.
      #2;
      i_if_req_valid = 1'b1;
      i_d_req_valid  = 1'b1;
      #1;
      check("rst_if_rsp_valid", {31'd0, o_if_rsp_valid}, 32'd0);
      check("rst_d_rsp_valid",  {31'd0, o_d_rsp_valid},  32'd0);
      check("rst_if_ready",     {31'd0, o_if_req_ready}, 32'd0);
      check("rst_d_ready",      {31'd0, o_d_req_ready},  32'd0);
      check("rst_mem_en",       {31'd0, o_mem_en},       32'd0);
      i_if_req_valid = 1'b0;
      i_d_req_valid  = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;

      // Fetch only, back to back.
      cycle(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h11);
      cycle(1, 32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h22);
      cycle(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h33);

      // Both valid: data read wins.
      cycle(1, 32'h8, 1, 0, 32'h100, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D);

      // Data write with partial strobes, then read it back.
      cycle(0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 0, 1, 32'h0);
      cycle(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'h0, 0, 1, 32'h1234_BEEF);

      // Idle: no memory access, and no response on the following cycle.
      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
      @(negedge i_clk);
      #1;
      check("idle_if_rsp_valid", {31'd0, o_if_rsp_valid}, 32'd0);
      check("idle_d_rsp_valid",  {31'd0, o_d_rsp_valid},  32'd0);
      check("idle_d_rsp_data",   o_d_rsp_data, 32'd0);

      // Continuous contention: 4 data grants then 1 fetch grant when fair,
      // fetch never granted otherwise.
      for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARBITER_FAIR_EN
         exp_if = (i % 5 == 4);
`else
         exp_if = 1'b0;
`endif
         cycle(1, 32'h8, 1, 0, 32'h0, 32'h0, 4'h0, exp_if, !exp_if,
               exp_if ? 32'h33 : 32'h11);
      end

      // Reset while a fetch response is in flight.
      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
      cycle(1, 32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h22);
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      if_q.delete();
      check("midrst_if_rsp_valid", {31'd0, o_if_rsp_valid}, 32'd0);
      check("midrst_if_rsp_data",  o_if_rsp_data, 32'd0);
      i_d_req_valid = 1'b1;
      #1;
      check("midrst_if_ready", {31'd0, o_if_req_ready}, 32'd0);
      check("midrst_d_ready",  {31'd0, o_d_req_ready},  32'd0);
      i_if_req_valid = 1'b0;
      i_d_req_valid  = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;

      // First grant after reset: plain data priority.
      cycle(1, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D);
      cycle(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h11);
      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);

      check("if_q_drained", if_q.size(), 32'd0);
      check("d_q_drained",  d_q.size(),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the instruction-fetch port and the data (load/store) port of the core. Arbitrates one access per cycle, drives the memory, and routes the read data back to the winning requester one cycle later. Sits between the fetch/memory stages and the unified memory macro. Data has priority; an optional anti-starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; must be a multiple of 8
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win (FAIR build only); legal range 1..15
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_if_req_valid  in  1  fetch read request
- o_if_req_ready  out  1  fetch request granted this cycle
- i_if_addr  in  ADDR_W  fetch address
- o_if_rsp_valid  out  1  fetch read data valid
- o_if_rsp_data  out  DATA_W  fetch read data
- i_d_req_valid  in  1  data request
- o_d_req_ready  out  1  data request granted this cycle
- i_d_addr  in  ADDR_W  data address
- i_d_we  in  1  1 = write, 0 = read
- i_d_wdata  in  DATA_W  write data
- i_d_wstrb  in  DATA_W/8  byte write enables
- o_d_rsp_valid  out  1  data read data valid, or write acknowledge
- o_d_rsp_data  out  DATA_W  data read data; 0 for write acks
- o_mem_en  out  1  memory access this cycle
- o_mem_addr  out  ADDR_W  memory address
- o_mem_we  out  1  memory write enable
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_wstrb  out  DATA_W/8  memory byte enables
- i_mem_rdata  in  DATA_W  memory read data, valid the cycle after a read

## Operation
- Grant is combinational from the request valids and state. At most one of o_if_req_ready / o_d_req_ready is high per cycle, and each is high only when its valid is high.
- Default policy: data wins whenever i_d_req_valid = 1; fetch wins only when data is idle.
- Grant drives o_mem_en = 1 with the winner's address; fetch forces o_mem_we = 0 and o_mem_wstrb = 0. With no grant: o_mem_en = 0, o_mem_we = 0, o_mem_wstrb = 0, address/wdata = 0.
- Owner register (NONE / IF / D_RD / D_WR) records the granted requester; it is updated every cycle, so back-to-back grants pipeline with no bubble.
- Response cycle: owner IF -> o_if_rsp_valid = 1, o_if_rsp_data = i_mem_rdata. Owner D_RD -> o_d_rsp_valid = 1, o_d_rsp_data = i_mem_rdata. Owner D_WR -> o_d_rsp_valid = 1, o_d_rsp_data = 0. Owner NONE -> both valids 0, both data outputs 0.
- Responses have no backpressure; requesters must accept them.
- A request held with valid = 1 and not granted must keep its address/data stable; the arbiter does not latch requests.

## Timing
- Grant latency: 0 cycles (same-cycle ready). Response latency: exactly 1 cycle after the grant.
- Throughput: one access per cycle, sustained.
- Reset (async, any time): owner <- NONE, starvation counter <- 0. All rsp_valid outputs read 0 immediately. An in-flight response is dropped, and the requester reissues it. Grant outputs remain combinational during reset but are forced to 0 while i_rst = 1.
- Simultaneous valid on both ports: data wins unless the fairness override applies (see Configuration).
- Dropping a request valid the cycle after its grant has no effect on the already-issued response.

## Configuration
- MEM_ARBITER_FAIR_EN defined: a 4-bit starvation counter increments each cycle fetch is valid but not granted. It clears on any fetch grant or when fetch valid = 0. When counter = STARVE_MAX, fetch wins over data for that cycle.
- Undefined: strict data priority. Fetch can be starved indefinitely, and no counter is instantiated.

## Structure
- Package mem_arbiter_pkg: owner_e enum (NONE, IF, D_RD, D_WR) and default width localparams.
- Optional sub-module arb_starve_ctr (saturating counter plus compare), instantiated only under MEM_ARBITER_FAIR_EN. All other logic stays flat.

## Test plan
- Fetch only, addresses 0x0, 0x4, 0x8 on consecutive cycles with memory returning 0x11, 0x22, 0x33 -> ready each cycle; o_if_rsp_valid on cycles 1-3 with data 0x11, 0x22, 0x33.
- Both valid, data read at 0x100 -> o_d_req_ready = 1, o_if_req_ready = 0, o_mem_addr = 0x100; next cycle o_d_rsp_valid = 1 and o_if_rsp_valid = 0.
- Data write at 0x40, wdata 0xDEADBEEF, wstrb 0b0011 -> o_mem_we = 1, o_mem_wstrb = 0b0011; next cycle o_d_rsp_valid = 1, o_d_rsp_data = 0.
- FAIR build, STARVE_MAX = 4, both valid continuously -> grant pattern repeats 4 data grants then 1 fetch grant. Non-FAIR build -> fetch is never granted.
- i_rst asserted mid-cycle while owner = IF -> o_if_rsp_valid drops to 0 immediately; after release, the first grant behaves as from reset.
- Neither valid -> o_mem_en = 0 and no rsp_valid on the following cycle.
